// File: rtl/agc_servo_loop.sv
// agc_servo_loop: closed-loop AGC controller for NCHAN channels.
// Requests an accumulation period, then compares each channel's gt+lt
// threshold count with a target. It steps each channel's scale up or down
// with saturation and issues one load strobe that covers all channels.
// Optional feature macro: AGC_SERVO_OFFSET_EN adds a per-channel signed
// offset servo driven by the gt-lt balance.
module agc_servo_loop #(
    parameter int                 NCHAN      = 8,
    parameter int                 ACCBITS    = 21,
    parameter int                 SCALEBITS  = 17,
    parameter logic [SCALEBITS-1:0] SCALE_INIT = 17'h10000,
    parameter int                 TIMEOUT    = 65536
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         run_i,
    input  logic                         accum_valid_i,
    input  logic [NCHAN*ACCBITS-1:0]     gt_accum_i,
    input  logic [NCHAN*ACCBITS-1:0]     lt_accum_i,
    input  logic [ACCBITS:0]             target_i,
    input  logic [ACCBITS-1:0]           deadband_i,
    input  logic [SCALEBITS-1:0]         step_i,
`ifdef AGC_SERVO_OFFSET_EN
    input  logic [15:0]                  offset_step_i,
    output logic [NCHAN*16-1:0]          offset_o,
`endif
    output logic                         tick_o,
    output logic [NCHAN*SCALEBITS-1:0]   scale_o,
    output logic                         scale_load_o,
    output logic                         busy_o,
    output logic [NCHAN-1:0]             sat_o,
    output logic                         timeout_o,
    output logic [15:0]                  iter_o
);

    localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int TMRW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCHAN - 1);
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TICK,
        S_WAIT,
        S_EVAL,
        S_LOAD
    } state_t;

    state_t                 state_q;
    logic [CHW-1:0]         ch_q;
    logic [TMRW-1:0]        timer_q;
    logic [SCALEBITS-1:0]   scale_q [NCHAN];
    logic [NCHAN-1:0]       sat_q;
    logic                   timeout_q;
    logic [15:0]            iter_q;
    logic                   tick_q;
    logic                   load_q;
    logic                   busy_q;

    // Unpacked views of the flat accumulator buses (ch0 in the LSBs).
    logic [ACCBITS-1:0]     gt_arr [NCHAN];
    logic [ACCBITS-1:0]     lt_arr [NCHAN];

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            assign gt_arr[gi] = gt_accum_i[gi*ACCBITS +: ACCBITS];
            assign lt_arr[gi] = lt_accum_i[gi*ACCBITS +: ACCBITS];
            assign scale_o[gi*SCALEBITS +: SCALEBITS] = scale_q[gi];
        end
    endgenerate

    logic [ACCBITS-1:0]        gt_sel;
    logic [ACCBITS-1:0]        lt_sel;
    logic [ACCBITS:0]          sum;
    logic signed [ACCBITS+1:0] err;
    logic signed [ACCBITS+1:0] db;
    logic [SCALEBITS:0]        scale_dn;
    logic [SCALEBITS:0]        scale_up;
    logic [SCALEBITS-1:0]      scale_d;
    logic                      scale_sat;

    // Error against target for the channel under evaluation, then the
    // saturating scale step. Borrow/carry in the extra MSB flags the clamp.
    always_comb begin
        gt_sel    = gt_arr[ch_q];
        lt_sel    = lt_arr[ch_q];
        sum       = {1'b0, gt_sel} + {1'b0, lt_sel};
        err       = $signed({1'b0, sum}) - $signed({1'b0, target_i});
        db        = $signed({2'b00, deadband_i});
        scale_dn  = {1'b0, scale_q[ch_q]} - {1'b0, step_i};
        scale_up  = {1'b0, scale_q[ch_q]} + {1'b0, step_i};
        scale_d   = scale_q[ch_q];
        scale_sat = 1'b0;
        if (err > db) begin
            if (scale_dn[SCALEBITS]) begin
                scale_d   = '0;
                scale_sat = 1'b1;
            end else begin
                scale_d   = scale_dn[SCALEBITS-1:0];
            end
        end else if (err < -db) begin
            if (scale_up[SCALEBITS]) begin
                scale_d   = '1;
                scale_sat = 1'b1;
            end else begin
                scale_d   = scale_up[SCALEBITS-1:0];
            end
        end
    end

`ifdef AGC_SERVO_OFFSET_EN
    logic signed [15:0]        offset_q [NCHAN];
    logic signed [ACCBITS+1:0] bal;
    logic signed [17:0]        off_cur;
    logic signed [17:0]        off_stp;
    logic signed [17:0]        off_dn;
    logic signed [17:0]        off_up;
    logic signed [15:0]        offset_d;
    logic                      offset_sat;

    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_off
            assign offset_o[gi*16 +: 16] = offset_q[gi];
        end
    endgenerate

    // Offset servo: positive balance (more gt than lt) pulls the offset down.
    always_comb begin
        bal        = $signed({2'b00, gt_sel}) - $signed({2'b00, lt_sel});
        off_cur    = {{2{offset_q[ch_q][15]}}, offset_q[ch_q]};
        off_stp    = $signed({2'b00, offset_step_i});
        off_dn     = off_cur - off_stp;
        off_up     = off_cur + off_stp;
        offset_d   = offset_q[ch_q];
        offset_sat = 1'b0;
        if (bal > db) begin
            if (off_dn < -18'sd32768) begin
                offset_d   = 16'sh8000;
                offset_sat = 1'b1;
            end else begin
                offset_d   = off_dn[15:0];
            end
        end else if (bal < -db) begin
            if (off_up > 18'sd32767) begin
                offset_d   = 16'sh7FFF;
                offset_sat = 1'b1;
            end else begin
                offset_d   = off_up[15:0];
            end
        end
    end

    // Offset registers update alongside the scale for the same channel.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NCHAN; i++) offset_q[i] <= '0;
        end else if (state_q == S_EVAL) begin
            offset_q[ch_q] <= offset_d;
        end
    end
`else
    logic offset_sat;
    assign offset_sat = 1'b0;
`endif

    // Servo sequencer: tick, wait for accumulators, evaluate channels, load.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            timer_q   <= '0;
            for (int i = 0; i < NCHAN; i++) scale_q[i] <= SCALE_INIT;
            sat_q     <= '0;
            timeout_q <= 1'b0;
            iter_q    <= '0;
            tick_q    <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q   <= S_TICK;
                        tick_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        sat_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_TICK: begin
                    state_q <= S_WAIT;
                    timer_q <= '0;
                end
                S_WAIT: begin
                    if (accum_valid_i) begin
                        state_q <= S_EVAL;
                        ch_q    <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMRW'(1);
                    end
                end
                S_EVAL: begin
                    scale_q[ch_q] <= scale_d;
                    if (scale_sat || offset_sat) sat_q[ch_q] <= 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        // Count moves with the load strobe so both are seen together.
                        iter_q  <= iter_q + 16'd1;
                    end else begin
                        ch_q <= ch_q + CHW'(1);
                    end
                end
                S_LOAD: begin
                    if (run_i) begin
                        state_q   <= S_TICK;
                        tick_q    <= 1'b1;
                        sat_q     <= '0;
                        timeout_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tick_o       = tick_q;
    assign scale_load_o = load_q;
    assign busy_o       = busy_q;
    assign sat_o        = sat_q;
    assign timeout_o    = timeout_q;
    assign iter_o       = iter_q;

endmodule

// File: tb/tb_agc_servo_loop.sv
// Directed bench for agc_servo_loop: gain stepping, deadband boundaries,
// saturation, timeout, run_i drop and reset mid-evaluation.
module tb_agc_servo_loop;

    localparam int NCHAN     = 8;
    localparam int ACCBITS   = 21;
    localparam int SCALEBITS = 17;
    localparam int TMO       = 64;

    logic                       aclk = 1'b0;
    logic                       aresetn = 1'b0;
    logic                       run_i = 1'b0;
    logic                       accum_valid_i = 1'b0;
    logic [NCHAN*ACCBITS-1:0]   gt_accum_i = '0;
    logic [NCHAN*ACCBITS-1:0]   lt_accum_i = '0;
    logic [ACCBITS:0]           target_i = '0;
    logic [ACCBITS-1:0]         deadband_i = '0;
    logic [SCALEBITS-1:0]       step_i = '0;
    logic                       tick_o;
    logic [NCHAN*SCALEBITS-1:0] scale_o;
    logic                       scale_load_o;
    logic                       busy_o;
    logic [NCHAN-1:0]           sat_o;
    logic                       timeout_o;
    logic [15:0]                iter_o;
`ifdef AGC_SERVO_OFFSET_EN
    logic [15:0]                offset_step_i = 16'h0010;
    logic [NCHAN*16-1:0]        offset_o;
`endif

    agc_servo_loop #(
        .NCHAN(NCHAN), .ACCBITS(ACCBITS), .SCALEBITS(SCALEBITS),
        .SCALE_INIT(17'h10000), .TIMEOUT(TMO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .run_i(run_i),
        .accum_valid_i(accum_valid_i),
        .gt_accum_i(gt_accum_i), .lt_accum_i(lt_accum_i),
        .target_i(target_i), .deadband_i(deadband_i), .step_i(step_i),
`ifdef AGC_SERVO_OFFSET_EN
        .offset_step_i(offset_step_i), .offset_o(offset_o),
`endif
        .tick_o(tick_o), .scale_o(scale_o), .scale_load_o(scale_load_o),
        .busy_o(busy_o), .sat_o(sat_o), .timeout_o(timeout_o), .iter_o(iter_o)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    function automatic logic [NCHAN*SCALEBITS-1:0] all_scales(input logic [SCALEBITS-1:0] v);
        logic [NCHAN*SCALEBITS-1:0] r;
        for (int i = 0; i < NCHAN; i++) r[i*SCALEBITS +: SCALEBITS] = v;
        return r;
    endfunction

    task automatic set_all(input int gt, input int lt);
        for (int i = 0; i < NCHAN; i++) begin
            gt_accum_i[i*ACCBITS +: ACCBITS] = ACCBITS'(gt);
            lt_accum_i[i*ACCBITS +: ACCBITS] = ACCBITS'(lt);
        end
    endtask

    task automatic set_ch(input int ch, input int gt, input int lt);
        gt_accum_i[ch*ACCBITS +: ACCBITS] = ACCBITS'(gt);
        lt_accum_i[ch*ACCBITS +: ACCBITS] = ACCBITS'(lt);
    endtask

    // Negedges until tick_o is seen (bounded; 99 means never).
    task automatic wait_tick(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge aclk);
            if (tick_o) begin n = i; break; end
        end
    endtask

    // One-cycle accum_valid_i pulse issued while the DUT waits; returns
    // at the negedge of the first evaluation cycle.
    task automatic pulse_valid();
        @(negedge aclk);
        accum_valid_i = 1'b1;
        @(negedge aclk);
        accum_valid_i = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge aclk);
            if (scale_load_o) begin n = i; break; end
        end
    endtask

    // Full iteration; lat = cycles from the accum_valid_i sample edge to scale_load_o.
    task automatic run_iter(output int nt, output int lat);
        int nl;
        wait_tick(nt);
        pulse_valid();
        wait_load(nl);
        lat = 1 + nl;
    endtask

    logic [NCHAN*SCALEBITS-1:0] exp_sc;
    int nt, lat, n, ticks;

    initial begin
        // ---- reset state
        repeat (3) @(negedge aclk);
        chk("rst_scale",   scale_o, all_scales(17'h10000));
        chk("rst_tick",    tick_o, 0);
        chk("rst_load",    scale_load_o, 0);
        chk("rst_busy",    busy_o, 0);
        chk("rst_sat",     sat_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_iter",    iter_o, 0);
        aresetn = 1'b1;

        // ---- 1: sum 2000 vs target 1000 -> every scale steps down by 0x100
        target_i = 1000; deadband_i = 10; step_i = 17'h00100;
        set_all(1000, 1000);
        @(negedge aclk);
        run_i = 1'b1;
        run_iter(nt, lat);
        chk("t1_first_tick", nt, 1);
        chk("t1_latency",    lat, 9);
        chk("t1_scale",      scale_o, all_scales(17'h0FF00));
        chk("t1_iter",       iter_o, 1);

        // ---- 2: in band, both deadband edges, then just outside
        set_all(500, 500);
        run_iter(nt, lat);
        chk("t2_load_to_tick", nt, 1);
        chk("t2_inband_scale", scale_o, all_scales(17'h0FF00));
        set_all(495, 495);              // err = -10
        run_iter(nt, lat);
        chk("t2_lowedge_scale", scale_o, all_scales(17'h0FF00));
        set_all(505, 505);              // err = +10
        run_iter(nt, lat);
        chk("t2_highedge_scale", scale_o, all_scales(17'h0FF00));
        chk("t2_iter", iter_o, 4);
        set_all(506, 505);              // err = +11
        run_iter(nt, lat);
        chk("t2_outside_scale", scale_o, all_scales(17'h0FE00));
        chk("t2_busy", busy_o, 1);

        // ---- 3: ch3 starved, large step drives it into the upper clamp
        set_all(500, 500);
        set_ch(3, 0, 0);
        step_i = 17'h10000;
        run_iter(nt, lat);
        exp_sc = all_scales(17'h0FE00);
        exp_sc[3*SCALEBITS +: SCALEBITS] = 17'h1FE00;
        chk("t3_scale_step", scale_o, exp_sc);
        chk("t3_sat_none",   sat_o, 0);
        run_iter(nt, lat);
        exp_sc[3*SCALEBITS +: SCALEBITS] = 17'h1FFFF;
        chk("t3_scale_clamp", scale_o, exp_sc);
        chk("t3_sat_ch3",     sat_o, 8'h08);
        chk("t3_iter",        iter_o, 7);

        // ---- 4: no accum_valid_i -> WAIT lasts TMO cycles, then timeout and IDLE
        step_i = 17'h00100;
        set_all(500, 500);
        wait_tick(nt);
        chk("t4_tick_clears_sat", sat_o, 0);
        run_i = 1'b0;
        n = 999;
        for (int i = 1; i <= 200; i++) begin
            @(negedge aclk);
            if (timeout_o) begin n = i; break; end
        end
        chk("t4_timeout_cycle", n, TMO + 1);
        chk("t4_busy",  busy_o, 0);
        chk("t4_scale", scale_o, exp_sc);
        chk("t4_iter",  iter_o, 7);
        repeat (3) @(negedge aclk);
        chk("t4_timeout_sticky", timeout_o, 1);
        run_i = 1'b1;
        run_iter(nt, lat);
        chk("t4_restart_lat",  lat, 9);
        chk("t4_timeout_clr",  timeout_o, 0);
        chk("t4_restart_iter", iter_o, 8);

        // ---- 5: drop run_i during ch2 evaluation -> load still issued, then IDLE
        wait_tick(nt);
        pulse_valid();
        repeat (2) @(negedge aclk);
        run_i = 1'b0;
        wait_load(n);
        chk("t5_latency", 3 + n, 9);
        chk("t5_iter",    iter_o, 9);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (tick_o) ticks++;
        end
        chk("t5_no_tick", ticks, 0);
        chk("t5_idle",    busy_o, 0);
        accum_valid_i = 1'b1;
        @(negedge aclk);
        accum_valid_i = 1'b0;
        repeat (12) @(negedge aclk);
        chk("t5_valid_ignored_busy",  busy_o, 0);
        chk("t5_valid_ignored_scale", scale_o, exp_sc);

        // ---- 6: reset asserted during ch4 evaluation discards partial updates
        set_all(1000, 1000);
        run_i = 1'b1;
        wait_tick(nt);
        pulse_valid();
        repeat (4) @(negedge aclk);
        chk("t6_ch0_updated", scale_o[0 +: SCALEBITS], 17'h0FD00);
        chk("t6_ch4_pending", scale_o[4*SCALEBITS +: SCALEBITS], 17'h0FE00);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_scale", scale_o, all_scales(17'h10000));
        chk("t6_rst_busy",  busy_o, 0);
        chk("t6_rst_iter",  iter_o, 0);
        chk("t6_rst_tick",  tick_o, 0);
        chk("t6_rst_load",  scale_load_o, 0);
        chk("t6_rst_sat",   sat_o, 0);
`ifdef AGC_SERVO_OFFSET_EN
        chk("t6_rst_offset", offset_o, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        step_i = 17'h00010;
        set_all(600, 400);
        run_iter(nt, lat);
        chk("t6_offset", offset_o, {NCHAN{16'hFFF0}});
        chk("t6_offset_scale", scale_o, all_scales(17'h10000));
`endif
        @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
